// File: rtl/instr_fetch_if.sv
// Fetch-to-CPU instruction handshake: the fetch stage drives the word and its
// valid flag, the CPU answers with ready.
interface instr_fetch_if;
    logic [11:0] instruction;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output instruction,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instruction,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: writable program memory, a program counter started by
// a pulse, and a valid/ready presentation of one instruction at a time to the CPU.
module instr_fetch #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [11:0]       load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    instr_fetch_if.master     fetch,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [11:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [11:0]       mem_q [DEPTH];

    logic              advance;
    logic              start_ok;
    logic [ADDR_W:0]   pc_inc;

    // Program memory write port; writes are locked out while a program is running.
    always_ff @(posedge clk) begin
        if (load_en && !busy_q) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Handshake qualifiers and the widened PC used for the length compare.
    always_comb begin
        advance  = (state_q == S_RUN) && (!valid_q || fetch.instr_ready);
        start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        pc_inc   = {1'b0, pc_q} + {{ADDR_W{1'b0}}, 1'b1};
    end

    // State register and all datapath/status flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= {ADDR_W{1'b0}};
            len_q   <= {(ADDR_W+1){1'b0}};
            instr_q <= 12'h000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d = (prog_len == {(ADDR_W+1){1'b0}}) ? S_DONE : S_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (advance && (pc_inc == len_q)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (fetch.instr_ready) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates; status flags are decoded from the next state so they stay registered.
    always_comb begin
        pc_d    = pc_q;
        len_d   = len_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    len_d   = prog_len;
                    pc_d    = {ADDR_W{1'b0}};
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            S_RUN: begin
                // PC wraps to 0 after the last word of a full-depth program; RUN is left anyway.
                if (advance) begin
                    instr_d = mem_q[pc_q];
                    valid_d = 1'b1;
                    pc_d    = pc_inc[ADDR_W-1:0];
                end else begin
                    valid_d = valid_q;
                end
            end
            S_DRAIN: begin
                if (fetch.instr_ready) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    assign fetch.instruction = instr_q;
    assign fetch.instr_valid = valid_q;
    assign pc                = pc_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule
